// File: rtl/prod_equiv_checker.sv
// prod_equiv_checker: watches two redundant copies of a producer and flags the
// first divergence. The copy that runs ahead has its words buffered in a small
// FIFO until the trailing copy catches up and the pair can be compared.
module prod_equiv_checker #(
  parameter int unsigned WIDTH     = 160,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_STALL = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         check_en_i,
  input  logic                         left_valid_i,
  input  logic [WIDTH-1:0]             left_data_i,
  input  logic                         right_valid_i,
  input  logic [WIDTH-1:0]             right_data_i,
  output logic                         src_cand_equiv_o,
  output logic                         mismatch_o,
  output logic                         overflow_o,
  output logic                         stall_timeout_o,
  output logic [$clog2(DEPTH+1)-1:0]   lead_cnt_o,
  output logic                         lead_right_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StBal, StLAhead, StRAhead, StFail} state_e;

  state_e            state;
  logic [WIDTH-1:0]  fifoMem [DEPTH];
  logic [PtrW-1:0]   rdPtr, wrPtr;
  logic [CntW-1:0]   leadCnt;
  logic [7:0]        stallCnt;
  logic              equiv, mismatch, overflow, stallTimeout, leadRight;

  logic              ahead, leadValid, trailValid, fifoFull, stallHit;
  logic [WIDTH-1:0]  leadData, trailData, headData, wrData;
  logic [8:0]        stallInc;
  logic              mismatchHit, overflowHit, timeoutHit, failNow, balMismatch, wrEn;

  function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Map Left/Right onto leading/trailing roles and decode this cycle's violations.
  always_comb begin
    ahead      = (state == StLAhead) || (state == StRAhead);
    leadValid  = 1'b0;
    trailValid = 1'b0;
    leadData   = left_data_i;
    trailData  = right_data_i;
    case (state)
      StLAhead: begin
        leadValid  = left_valid_i;
        trailValid = right_valid_i;
      end
      StRAhead: begin
        leadValid  = right_valid_i;
        leadData   = right_data_i;
        trailValid = left_valid_i;
        trailData  = left_data_i;
      end
      default: ;
    endcase
    headData    = fifoMem[rdPtr];
    fifoFull    = (leadCnt == CntW'(DEPTH));
    stallInc    = {1'b0, stallCnt} + 9'd1;
    stallHit    = (stallInc >= 9'(MAX_STALL));
    mismatchHit = trailValid && (headData != trailData);
    // A full FIFO is fine when the same cycle also pops a word.
    overflowHit = leadValid && !trailValid && fifoFull;
    timeoutHit  = ahead && !trailValid && stallHit;
    failNow     = check_en_i && ahead && (mismatchHit || overflowHit || timeoutHit);
    balMismatch = left_valid_i && right_valid_i && (left_data_i != right_data_i);
  end

  // FIFO write side: select the word of whichever copy is currently ahead.
  always_comb begin
    wrData = leadData;
    wrEn   = 1'b0;
    if (state == StBal) begin
      wrData = left_valid_i ? left_data_i : right_data_i;
    end
    if (check_en_i) begin
      if (state == StBal) begin
        wrEn = left_valid_i ^ right_valid_i;
      end else if (ahead) begin
        wrEn = leadValid && !failNow;
      end
    end
  end

  // Storage only; occupancy lives in the control registers below.
  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      fifoMem[wrPtr] <= wrData;
    end
  end

  // Checker FSM with FIFO pointers, stall counter and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= StBal;
      rdPtr        <= '0;
      wrPtr        <= '0;
      leadCnt      <= '0;
      stallCnt     <= '0;
      equiv        <= 1'b1;
      mismatch     <= 1'b0;
      overflow     <= 1'b0;
      stallTimeout <= 1'b0;
      leadRight    <= 1'b0;
    end else if (check_en_i) begin
      case (state)
        StBal: begin
          stallCnt <= '0;
          if (left_valid_i && right_valid_i) begin
            if (balMismatch) begin
              state    <= StFail;
              equiv    <= 1'b0;
              mismatch <= 1'b1;
            end
          end else if (left_valid_i || right_valid_i) begin
            state     <= left_valid_i ? StLAhead : StRAhead;
            leadRight <= right_valid_i;
            leadCnt   <= CntW'(1);
            wrPtr     <= ptrInc(wrPtr);
          end
        end
        StLAhead, StRAhead: begin
          if (failNow) begin
            // Buffer and counters freeze as they were; only the flags move.
            state <= StFail;
            equiv <= 1'b0;
            if (mismatchHit) mismatch     <= 1'b1;
            if (overflowHit) overflow     <= 1'b1;
            if (timeoutHit)  stallTimeout <= 1'b1;
          end else begin
            stallCnt <= trailValid ? 8'd0 : stallInc[7:0];
            if (leadValid)  wrPtr <= ptrInc(wrPtr);
            if (trailValid) rdPtr <= ptrInc(rdPtr);
            if (leadValid && !trailValid) begin
              leadCnt <= leadCnt + CntW'(1);
            end else if (trailValid && !leadValid) begin
              leadCnt <= leadCnt - CntW'(1);
              if (leadCnt == CntW'(1)) begin
                state     <= StBal;
                leadRight <= 1'b0;
                stallCnt  <= '0;
              end
            end
          end
        end
        default: ;  // StFail absorbs until reset
      endcase
    end
  end

  assign src_cand_equiv_o = equiv;
  assign mismatch_o       = mismatch;
  assign overflow_o       = overflow;
  assign stall_timeout_o  = stallTimeout;
  assign lead_cnt_o       = leadCnt;
  assign lead_right_o     = leadRight;

endmodule

// File: doc/prod_equiv_checker.md
PROD_EQUIV_CHECKER -- requirements
Module: prod_equiv_checker

Interface
REQ-001 Parameter WIDTH, default 160: bit width of each observed output word per copy.
REQ-002 Parameter DEPTH, default 4: maximum number of words one copy may lead the other; legal range 1..64.
REQ-003 Parameter MAX_STALL, default 16: cycle limit for the trailing copy to produce a word while the other leads; legal range 1..255.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 check_en_i  input  1  observation enable; low freezes all state and ignores valids.
REQ-007 left_valid_i  input  1  Left copy presents an observable word this cycle.
REQ-008 left_data_i  input  WIDTH  Left copy observable word.
REQ-009 right_valid_i  input  1  Right copy presents an observable word this cycle.
REQ-010 right_data_i  input  WIDTH  Right copy observable word.
REQ-011 src_cand_equiv_o  output  1  high while no violation detected since reset.
REQ-012 mismatch_o  output  1  sticky; a compared Left/Right word pair differed.
REQ-013 overflow_o  output  1  sticky; lead exceeded DEPTH.
REQ-014 stall_timeout_o  output  1  sticky; trailing copy silent for MAX_STALL cycles.
REQ-015 lead_cnt_o  output  $clog2(DEPTH+1)  number of buffered words of the leading copy.
REQ-016 lead_right_o  output  1  1 = Right leads, 0 = Left leads or balanced.

Function
REQ-017 FSM states: BAL (buffer empty), L_AHEAD, R_AHEAD, FAIL; FAIL is absorbing until reset.
REQ-018 One FIFO of DEPTH entries x WIDTH holds the leading copy's words in order.
REQ-019 BAL, both valid: compare left_data_i vs right_data_i directly; equal -> stay BAL; differ -> FAIL, mismatch_o=1.
REQ-020 BAL, only one valid: push word, go to L_AHEAD or R_AHEAD accordingly; lead_cnt_o=1.
REQ-021 X_AHEAD, only leading copy valid: push; if FIFO already full -> FAIL, overflow_o=1, no push.
REQ-022 X_AHEAD, only trailing copy valid: pop head, compare with trailing word; differ -> FAIL, mismatch_o=1; equal and FIFO becomes empty -> BAL.
REQ-023 X_AHEAD, both valid: pop head compared with trailing word and push leading word in the same cycle; count unchanged; full FIFO is not overflow in this case.
REQ-024 Stall counter (8 bit) increments each enabled cycle in X_AHEAD without trailing-copy valid; clears on any trailing valid or on entry to BAL.
REQ-025 Stall counter reaching MAX_STALL -> FAIL, stall_timeout_o=1 on the following edge.
REQ-026 Several violations in one cycle: set every applicable sticky flag.
REQ-027 All outputs registered; a violation on edge N is visible after edge N; src_cand_equiv_o = (state != FAIL).
REQ-028 check_en_i low: no push, pop, compare, or counter change; FSM holds.
REQ-029 In FAIL, inputs ignored; lead_cnt_o, lead_right_o, and flags hold.

Reset
REQ-030 rst_ni low asynchronously forces: BAL, FIFO pointers 0, stall counter 0, src_cand_equiv_o=1, mismatch_o=0, overflow_o=0, stall_timeout_o=0, lead_cnt_o=0, lead_right_o=0.
REQ-031 Reset mid-operation (any state, including FAIL) discards buffered words; checking restarts in BAL on the first edge after deassertion.

Verification
REQ-032 Lockstep: 20 cycles both valid, identical data 0x1..0x14 -> src_cand_equiv_o=1, lead_cnt_o=0 throughout.
REQ-033 Skew: Left sends A,B,C; Right sends A,B,C 3 cycles later -> lead_cnt_o peaks at 3, lead_right_o=0, returns to BAL, no flags.
REQ-034 Mismatch: Right leads with 0xAA; Left later sends 0xAB -> mismatch_o=1, src_cand_equiv_o=0 one cycle after the compare, held until reset.
REQ-035 Overflow: DEPTH=4; Left sends 5 words, Right silent -> overflow_o=1 on the 5th push; full FIFO with both valid -> no overflow.
REQ-036 Stall: MAX_STALL=16; Left sends 1 word, Right silent -> stall_timeout_o=1 after the 16th stalled cycle; check_en_i low cycles do not count.
REQ-037 Reset in FAIL with lead_cnt_o=2 -> all outputs at reset values asynchronously; a subsequent lockstep pair is accepted.
